// File: rtl/ddr_rw_arbiter_if.sv
// Command and handshake bundle between ddr_rw_arbiter (master) and the
// burst write/read engines plus the app_* mux (slave).
interface ddr_rw_arbiter_if #(
  parameter int ADDR_W = 29
);
  logic              wr_req;
  logic              rd_req;
  logic              wr_end;
  logic              rd_end;
  logic              wr_cmd_start;
  logic [ADDR_W-1:0] wr_cmd_addr;
  logic [7:0]        wr_cmd_bl;
  logic [2:0]        wr_cmd_intr;
  logic [63:0]       wr_cmd_mask;
  logic              rd_cmd_start;
  logic [ADDR_W-1:0] rd_cmd_addr;
  logic [7:0]        rd_cmd_bl;
  logic [2:0]        rd_cmd_intr;
  logic              app_sel;

  modport master (
    input  wr_req, rd_req, wr_end, rd_end,
    output wr_cmd_start, wr_cmd_addr, wr_cmd_bl, wr_cmd_intr, wr_cmd_mask,
    output rd_cmd_start, rd_cmd_addr, rd_cmd_bl, rd_cmd_intr, app_sel
  );

  modport slave (
    output wr_req, rd_req, wr_end, rd_end,
    input  wr_cmd_start, wr_cmd_addr, wr_cmd_bl, wr_cmd_intr, wr_cmd_mask,
    input  rd_cmd_start, rd_cmd_addr, rd_cmd_bl, rd_cmd_intr, app_sel
  );
endinterface

// File: rtl/ddr_rw_arbiter.sv
// Round-robin sequencer sharing the DDR4 MIG user interface between the
// capture write engine and the display read engine, one burst at a time.
module ddr_rw_arbiter #(
  parameter int                ADDR_W     = 29,
  parameter logic [7:0]        BURST_BL   = 8'd64,
  parameter logic [ADDR_W-1:0] WR_BASE    = '0,
  parameter logic [ADDR_W-1:0] RD_BASE    = '0,
  parameter logic [ADDR_W-1:0] FRAME_SIZE = 29'h3F4800,
  parameter logic [15:0]       TIMEOUT    = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              calib_done,
  input  logic              wr_frame_rst,
  input  logic              rd_frame_rst,
  ddr_rw_arbiter_if.master  bus,
  output logic              busy,
  output logic              wr_frame_done,
  output logic              rd_frame_done,
  output logic              timeout_err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ARB      = 3'd1;
  localparam logic [2:0] S_WR_START = 3'd2;
  localparam logic [2:0] S_WR_WAIT  = 3'd3;
  localparam logic [2:0] S_RD_START = 3'd4;
  localparam logic [2:0] S_RD_WAIT  = 3'd5;

  // One beat is 8 address units, so a burst advances the pointer by BL*8.
  localparam logic [ADDR_W-1:0] STEP   = ADDR_W'({BURST_BL, 3'b000});
  localparam logic [ADDR_W-1:0] WR_END = WR_BASE + FRAME_SIZE;
  localparam logic [ADDR_W-1:0] RD_END = RD_BASE + FRAME_SIZE;
  localparam logic [15:0]       TO_LAST = TIMEOUT - 16'd1;

  logic [2:0]        state;
  logic              last_grant;   // 0 = write, 1 = read
  logic [15:0]       tcnt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_rst_pend;
  logic              rd_rst_pend;

  logic              pick_wr;
  logic              pick_rd;
  logic              wr_active;
  logic              rd_active;
  logic              wr_done_now;
  logic              rd_done_now;
  logic [ADDR_W-1:0] wr_step;
  logic [ADDR_W-1:0] rd_step;

  assign pick_wr     = bus.wr_req & (~bus.rd_req | last_grant);
  assign pick_rd     = bus.rd_req & (~bus.wr_req | ~last_grant);
  assign wr_active   = (state == S_WR_START) || (state == S_WR_WAIT);
  assign rd_active   = (state == S_RD_START) || (state == S_RD_WAIT);
  assign wr_done_now = (state == S_WR_WAIT) && bus.wr_end;
  assign rd_done_now = (state == S_RD_WAIT) && bus.rd_end;
  assign wr_step     = wr_ptr + STEP;
  assign rd_step     = rd_ptr + STEP;

  assign busy            = wr_active || rd_active;
  assign bus.wr_cmd_bl   = BURST_BL;
  assign bus.wr_cmd_intr = 3'b000;
  assign bus.wr_cmd_mask = 64'd0;
  assign bus.rd_cmd_bl   = BURST_BL;
  assign bus.rd_cmd_intr = 3'b001;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      last_grant       <= 1'b1;
      tcnt             <= '0;
      bus.wr_cmd_start <= 1'b0;
      bus.rd_cmd_start <= 1'b0;
      bus.wr_cmd_addr  <= WR_BASE;
      bus.rd_cmd_addr  <= RD_BASE;
      bus.app_sel      <= 1'b0;
      timeout_err      <= 1'b0;
    end else begin
      bus.wr_cmd_start <= 1'b0;
      bus.rd_cmd_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (calib_done) state <= S_ARB;
        end
        S_ARB: begin
          // A frame restart seen in this cycle already applies to the captured address.
          if (!calib_done) begin
            state <= S_IDLE;
          end else if (pick_wr) begin
            state            <= S_WR_START;
            bus.wr_cmd_start <= 1'b1;
            bus.wr_cmd_addr  <= (wr_frame_rst || wr_rst_pend) ? WR_BASE : wr_ptr;
            bus.app_sel      <= 1'b0;
            last_grant       <= 1'b0;
          end else if (pick_rd) begin
            state            <= S_RD_START;
            bus.rd_cmd_start <= 1'b1;
            bus.rd_cmd_addr  <= (rd_frame_rst || rd_rst_pend) ? RD_BASE : rd_ptr;
            bus.app_sel      <= 1'b1;
            last_grant       <= 1'b1;
          end
        end
        S_WR_START: begin
          state <= S_WR_WAIT;
          tcnt  <= '0;
        end
        S_RD_START: begin
          state <= S_RD_WAIT;
          tcnt  <= '0;
        end
        S_WR_WAIT: begin
          if (bus.wr_end) begin
            state <= S_ARB;
          end else if (tcnt == TO_LAST) begin
            state       <= S_ARB;
            timeout_err <= 1'b1;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        S_RD_WAIT: begin
          if (bus.rd_end) begin
            state <= S_ARB;
          end else if (tcnt == TO_LAST) begin
            state       <= S_ARB;
            timeout_err <= 1'b1;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Write pointer: step on burst end, restart deferred while the side is mid-burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= WR_BASE;
      wr_rst_pend   <= 1'b0;
      wr_frame_done <= 1'b0;
    end else begin
      wr_frame_done <= 1'b0;
      if (wr_active) begin
        if (wr_done_now) begin
          if (wr_rst_pend || wr_frame_rst) begin
            wr_ptr      <= WR_BASE;
            wr_rst_pend <= 1'b0;
          end else if (wr_step == WR_END) begin
            wr_ptr        <= WR_BASE;
            wr_frame_done <= 1'b1;
          end else begin
            wr_ptr <= wr_step;
          end
        end else if (wr_frame_rst) begin
          wr_rst_pend <= 1'b1;
        end
      end else if (wr_frame_rst || wr_rst_pend) begin
        wr_ptr      <= WR_BASE;
        wr_rst_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr        <= RD_BASE;
      rd_rst_pend   <= 1'b0;
      rd_frame_done <= 1'b0;
    end else begin
      rd_frame_done <= 1'b0;
      if (rd_active) begin
        if (rd_done_now) begin
          if (rd_rst_pend || rd_frame_rst) begin
            rd_ptr      <= RD_BASE;
            rd_rst_pend <= 1'b0;
          end else if (rd_step == RD_END) begin
            rd_ptr        <= RD_BASE;
            rd_frame_done <= 1'b1;
          end else begin
            rd_ptr <= rd_step;
          end
        end else if (rd_frame_rst) begin
          rd_rst_pend <= 1'b1;
        end
      end else if (rd_frame_rst || rd_rst_pend) begin
        rd_ptr      <= RD_BASE;
        rd_rst_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ddr_rw_arbiter.sv
// Directed bench for ddr_rw_arbiter: FRAME_SIZE=0x800 (4 bursts), TIMEOUT=16,
// RD_BASE=0x1000 so read and write addresses are distinguishable.
module tb_ddr_rw_arbiter;
  localparam int            AW  = 29;
  localparam logic [AW-1:0] RDB = 29'h1000;

  logic clk = 1'b0;
  logic rst_n;
  logic calib_done;
  logic wr_frame_rst;
  logic rd_frame_rst;
  logic busy;
  logic wr_frame_done;
  logic rd_frame_done;
  logic timeout_err;

  int errors = 0;
  int checks = 0;
  int sel_glitch = 0;
  logic prev_sel = 1'b0;

  ddr_rw_arbiter_if #(.ADDR_W(AW)) bus ();

  ddr_rw_arbiter #(
    .ADDR_W(AW), .BURST_BL(8'd64), .WR_BASE(29'h0), .RD_BASE(RDB),
    .FRAME_SIZE(29'h800), .TIMEOUT(16'd16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .calib_done(calib_done),
    .wr_frame_rst(wr_frame_rst), .rd_frame_rst(rd_frame_rst),
    .bus(bus), .busy(busy), .wr_frame_done(wr_frame_done),
    .rd_frame_done(rd_frame_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // app_sel may only move in a cycle that shows a start pulse.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.app_sel !== prev_sel &&
        !bus.wr_cmd_start && !bus.rd_cmd_start)
      sel_glitch++;
    prev_sel = bus.app_sel;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_start(input int budget, output bit seen, output bit is_rd,
                            output logic [AW-1:0] addr, output logic sel, output int cyc);
    seen = 1'b0; is_rd = 1'b0; addr = '0; sel = 1'b0; cyc = 0;
    for (int i = 1; i <= budget && !seen; i++) begin
      @(negedge clk);
      if (bus.wr_cmd_start || bus.rd_cmd_start) begin
        seen  = 1'b1;
        is_rd = bus.rd_cmd_start;
        addr  = bus.rd_cmd_start ? bus.rd_cmd_addr : bus.wr_cmd_addr;
        sel   = bus.app_sel;
        cyc   = i;
      end
    end
  endtask

  // Called on a negedge; end is high across exactly one posedge.
  task automatic pulse_end(input bit is_rd, output logic done);
    if (is_rd) bus.rd_end = 1'b1; else bus.wr_end = 1'b1;
    @(negedge clk);
    done = is_rd ? rd_frame_done : wr_frame_done;
    bus.rd_end = 1'b0;
    bus.wr_end = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; calib_done = 1'b0; wr_frame_rst = 1'b0; rd_frame_rst = 1'b0;
    bus.wr_req = 1'b0; bus.rd_req = 1'b0; bus.wr_end = 1'b0; bus.rd_end = 1'b0;
    idle(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (bus.wr_cmd_start !== 1'b0 || bus.rd_cmd_start !== 1'b0) begin
      errors++; $display("FAIL reset_start: got wr=%b rd=%b want 0", bus.wr_cmd_start, bus.rd_cmd_start); end
    checks++; if (bus.app_sel !== 1'b0) begin errors++; $display("FAIL reset_app_sel: got %b want 0", bus.app_sel); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
    checks++; if (wr_frame_done !== 1'b0 || rd_frame_done !== 1'b0) begin
      errors++; $display("FAIL reset_frame_done: got wr=%b rd=%b want 0", wr_frame_done, rd_frame_done); end
    checks++; if (bus.wr_cmd_bl !== 8'd64 || bus.rd_cmd_bl !== 8'd64) begin
      errors++; $display("FAIL cmd_bl: got wr=%0d rd=%0d want 64", bus.wr_cmd_bl, bus.rd_cmd_bl); end
    checks++; if (bus.wr_cmd_intr !== 3'b000 || bus.rd_cmd_intr !== 3'b001 || bus.wr_cmd_mask !== 64'd0) begin
      errors++; $display("FAIL cmd_const: got wintr=%b rintr=%b mask=%h want 000 001 0",
                         bus.wr_cmd_intr, bus.rd_cmd_intr, bus.wr_cmd_mask); end
    rst_n = 1'b1;
  endtask

  task automatic test_no_calib();
    int starts = 0;
    int busy_cnt = 0;
    bus.wr_req = 1'b1; bus.rd_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.wr_cmd_start || bus.rd_cmd_start) starts++;
      if (busy) busy_cnt++;
    end
    checks++; if (starts != 0) begin errors++; $display("FAIL no_calib_starts: got %0d want 0", starts); end
    checks++; if (busy_cnt != 0) begin errors++; $display("FAIL no_calib_busy: got %0d want 0", busy_cnt); end
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;
  endtask

  task automatic test_write_seq();
    bit seen, is_rd; logic [AW-1:0] addr, exp_a; logic sel, done; int cyc;
    calib_done = 1'b1; bus.wr_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_start(30, seen, is_rd, addr, sel, cyc);
      exp_a = (k == 4) ? '0 : AW'(k * 512);
      checks++; if (!seen || is_rd || addr !== exp_a) begin
        errors++; $display("FAIL wr_seq_addr[%0d]: got seen=%b rd=%b addr=%h want write %h", k, seen, is_rd, addr, exp_a); end
      checks++; if (sel !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL wr_seq_sel_busy[%0d]: got sel=%b busy=%b want 0 1", k, sel, busy); end
      if (k == 4) begin
        checks++; if (wr_frame_done !== 1'b0) begin
          errors++; $display("FAIL wr_frame_done_width: got %b want 0", wr_frame_done); end
      end
      idle(4);
      if (k == 4) bus.wr_req = 1'b0;
      pulse_end(1'b0, done);
      checks++; if (done !== (k == 3)) begin
        errors++; $display("FAIL wr_frame_done[%0d]: got %b want %b", k, done, (k == 3)); end
    end
  endtask

  task automatic test_alternate();
    bit seen, is_rd, exp_rd; logic [AW-1:0] addr, exp_a; logic sel, done; int cyc;
    rst_n = 1'b0; idle(2);
    bus.wr_req = 1'b1; bus.rd_req = 1'b1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_start(30, seen, is_rd, addr, sel, cyc);
      exp_rd = (k % 2) == 1;
      exp_a  = exp_rd ? RDB + AW'((k / 2) * 512) : AW'((k / 2) * 512);
      checks++; if (!seen || is_rd !== exp_rd || addr !== exp_a) begin
        errors++; $display("FAIL alt_grant[%0d]: got seen=%b rd=%b addr=%h want rd=%b addr=%h", k, seen, is_rd, addr, exp_rd, exp_a); end
      checks++; if (sel !== exp_rd) begin
        errors++; $display("FAIL alt_app_sel[%0d]: got %b want %b", k, sel, exp_rd); end
      if (k > 0) begin
        checks++; if (cyc != 1) begin
          errors++; $display("FAIL alt_min_gap[%0d]: got %0d cycles after end want 1", k, cyc); end
      end
      idle(3);
      if (k == 3) begin bus.wr_req = 1'b0; bus.rd_req = 1'b0; end
      pulse_end(exp_rd, done);
    end
    checks++; if (sel_glitch != 0) begin errors++; $display("FAIL app_sel_glitch: got %0d want 0", sel_glitch); end
  endtask

  task automatic test_frame_rst();
    bit seen, is_rd; logic [AW-1:0] addr; logic sel, done; int cyc;
    bus.rd_req = 1'b1;
    wait_start(30, seen, is_rd, addr, sel, cyc);
    checks++; if (!seen || !is_rd || addr !== RDB + 29'h400) begin
      errors++; $display("FAIL frst_pre_addr: got seen=%b rd=%b addr=%h want %h", seen, is_rd, addr, RDB + 29'h400); end
    idle(2);
    rd_frame_rst = 1'b1; wr_frame_rst = 1'b1;
    @(negedge clk);
    rd_frame_rst = 1'b0; wr_frame_rst = 1'b0;
    idle(2);
    pulse_end(1'b1, done);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL frst_pend_done: got %b want 0", done); end
    wait_start(30, seen, is_rd, addr, sel, cyc);
    checks++; if (!seen || !is_rd || addr !== RDB) begin
      errors++; $display("FAIL frst_pend_addr: got seen=%b rd=%b addr=%h want %h", seen, is_rd, addr, RDB); end
    idle(3);
    rd_frame_rst = 1'b1;
    pulse_end(1'b1, done);
    rd_frame_rst = 1'b0;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL frst_same_done: got %b want 0", done); end
    wait_start(30, seen, is_rd, addr, sel, cyc);
    checks++; if (!seen || !is_rd || addr !== RDB) begin
      errors++; $display("FAIL frst_same_addr: got seen=%b rd=%b addr=%h want %h", seen, is_rd, addr, RDB); end
    bus.rd_req = 1'b0;
    idle(3);
    pulse_end(1'b1, done);
  endtask

  task automatic test_timeout();
    bit seen, is_rd; logic [AW-1:0] addr; logic sel, done; int cyc;
    int tcyc = 0;
    bus.wr_req = 1'b1;
    wait_start(30, seen, is_rd, addr, sel, cyc);
    checks++; if (!seen || is_rd || addr !== 29'h0) begin
      errors++; $display("FAIL idle_frame_rst_addr: got seen=%b rd=%b addr=%h want write 0", seen, is_rd, addr); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_err_before: got %b want 0", timeout_err); end
    for (int i = 1; i <= 40 && tcyc == 0; i++) begin
      @(negedge clk);
      if (!busy) tcyc = i;
    end
    checks++; if (tcyc != 17) begin errors++; $display("FAIL to_abort_cycles: got %0d want 17", tcyc); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_err_set: got %b want 1", timeout_err); end
    wait_start(30, seen, is_rd, addr, sel, cyc);
    checks++; if (!seen || is_rd || addr !== 29'h0 || cyc != 1) begin
      errors++; $display("FAIL to_retry_addr: got seen=%b rd=%b addr=%h cyc=%0d want write 0 cyc 1", seen, is_rd, addr, cyc); end
    idle(3);
    bus.wr_req = 1'b0;
    pulse_end(1'b0, done);
    checks++; if (timeout_err !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL to_err_sticky: got err=%b done=%b want 1 0", timeout_err, done); end
  endtask

  task automatic test_calib_drop();
    bit seen, is_rd; logic [AW-1:0] addr; logic sel, done; int cyc;
    int starts = 0;
    bus.wr_req = 1'b1;
    wait_start(30, seen, is_rd, addr, sel, cyc);
    checks++; if (!seen || is_rd || addr !== 29'h200) begin
      errors++; $display("FAIL cd_addr: got seen=%b rd=%b addr=%h want write 200", seen, is_rd, addr); end
    pulse_end(1'b0, done);
    idle(3);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL end_in_start_ignored: got busy=%b want 1", busy); end
    calib_done = 1'b0;
    idle(1);
    pulse_end(1'b0, done);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.wr_cmd_start || bus.rd_cmd_start) starts++;
    end
    checks++; if (starts != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL cd_idle: got starts=%0d busy=%b want 0 0", starts, busy); end
    calib_done = 1'b1;
    wait_start(30, seen, is_rd, addr, sel, cyc);
    checks++; if (!seen || is_rd || addr !== 29'h400) begin
      errors++; $display("FAIL cd_resume_addr: got seen=%b rd=%b addr=%h want write 400", seen, is_rd, addr); end
    bus.wr_req = 1'b0;
    idle(3);
    pulse_end(1'b0, done);
  endtask

  task automatic test_reset_mid();
    bit seen, is_rd; logic [AW-1:0] addr; logic sel; int cyc;
    bus.rd_req = 1'b1;
    wait_start(30, seen, is_rd, addr, sel, cyc);
    checks++; if (!seen || !is_rd || addr !== RDB + 29'h200 || sel !== 1'b1) begin
      errors++; $display("FAIL rm_addr: got seen=%b rd=%b addr=%h sel=%b want read %h sel 1", seen, is_rd, addr, sel, RDB + 29'h200); end
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || bus.app_sel !== 1'b0 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL async_reset: got busy=%b sel=%b err=%b want 0 0 0", busy, bus.app_sel, timeout_err); end
    @(negedge clk);
    rst_n = 1'b1;
    wait_start(30, seen, is_rd, addr, sel, cyc);
    checks++; if (!seen || !is_rd || addr !== RDB) begin
      errors++; $display("FAIL rm_ptr_reset: got seen=%b rd=%b addr=%h want read %h", seen, is_rd, addr, RDB); end
    bus.rd_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_no_calib();
    test_write_seq();
    test_alternate();
    test_frame_rst();
    test_timeout();
    test_calib_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
